// File: rtl/axis_multi_producer.sv
// axis_multi_producer: NUM_CH independent AXI4-Stream packet generators with programmable
// length, count and gap. Define AXIS_PRODUCER_LFSR_EN to add the cfg_mode=1 LFSR data pattern.
module axis_multi_producer #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned GAP_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        start,
    input  logic [NUM_CH-1:0]        stop,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic [CNT_W-1:0]         cfg_pkts,
    input  logic [GAP_W-1:0]         cfg_gap,
    input  logic [DATA_W-1:0]        cfg_seed,
    input  logic                     cfg_mode,
    output logic [NUM_CH-1:0]        tvalid,
    input  logic [NUM_CH-1:0]        tready,
    output logic [NUM_CH-1:0]        tlast,
    output logic [NUM_CH*DATA_W-1:0] tdata,
    output logic [NUM_CH-1:0]        busy,
    output logic [NUM_CH-1:0]        done
);
    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    // Reset asserts asynchronously; start is held off until release has been synchronised.
    logic [1:0] rst_sync_q;
    logic       rst_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_ok = rst_sync_q[1];

`ifdef AXIS_PRODUCER_LFSR_EN
    function automatic logic [DATA_W-1:0] lfsr_taps();
        case (DATA_W)
            8:       return DATA_W'(8'hB8);
            16:      return DATA_W'(16'hB400);
            32:      return DATA_W'(32'h8020_0003);
            64:      return DATA_W'(64'hD800_0000_0000_0000);
            default: return {1'b1, {(DATA_W-2){1'b0}}, 1'b1};
        endcase
    endfunction

    localparam logic [DATA_W-1:0] LfsrTaps = lfsr_taps();

    function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] d);
        return {1'b0, d[DATA_W-1:1]} ^ (d[0] ? LfsrTaps : '0);
    endfunction
`else
    logic unused_mode;
    assign unused_mode = cfg_mode;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_e            state_q, state_d;
        logic [LEN_W-1:0]  len_q, len_d, beat_q, beat_d;
        logic [CNT_W-1:0]  pkts_q, pkts_d, pkt_cnt_q, pkt_cnt_d, pkt_inc;
        logic [GAP_W-1:0]  gap_q, gap_d, gap_cnt_q, gap_cnt_d;
        logic [DATA_W-1:0] data_q, data_d, data_adv;
        logic              stop_q, stop_d, done_q, done_d;
        logic              hs, last_beat, stop_seen, is_busy;
`ifdef AXIS_PRODUCER_LFSR_EN
        logic              mode_q, mode_d;
        assign data_adv = mode_q ? lfsr_step(data_q) : data_q + DATA_W'(1);
`else
        assign data_adv = data_q + DATA_W'(1);
`endif

        assign is_busy   = state_q != StIdle;
        assign hs        = (state_q == StSend) && tready[c];
        assign last_beat = beat_q == len_q - LEN_W'(1);
        assign stop_seen = stop_q | stop[c];
        assign pkt_inc   = pkt_cnt_q + CNT_W'(1);

        always_comb begin
            state_d   = state_q;
            len_d     = len_q;
            pkts_d    = pkts_q;
            gap_d     = gap_q;
            beat_d    = beat_q;
            pkt_cnt_d = pkt_cnt_q;
            gap_cnt_d = gap_cnt_q;
            data_d    = data_q;
            done_d    = 1'b0;
            stop_d    = is_busy ? stop_seen : 1'b0;
`ifdef AXIS_PRODUCER_LFSR_EN
            mode_d    = mode_q;
`endif
            unique case (state_q)
                StIdle: begin
                    if (start[c] && rst_ok) begin
                        len_d     = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
                        pkts_d    = cfg_pkts;
                        gap_d     = cfg_gap;
                        beat_d    = '0;
                        pkt_cnt_d = '0;
                        gap_cnt_d = '0;
                        stop_d    = 1'b0;
                        state_d   = StSend;
`ifdef AXIS_PRODUCER_LFSR_EN
                        mode_d    = cfg_mode;
                        // An all-zero LFSR state would never leave zero.
                        data_d    = (cfg_mode && cfg_seed == '0) ? '1 : cfg_seed;
`else
                        data_d    = cfg_seed;
`endif
                    end
                end
                StSend: begin
                    if (hs) begin
                        data_d = data_adv;
                        if (last_beat) begin
                            beat_d    = '0;
                            pkt_cnt_d = pkt_inc;
                            if (stop_seen || (pkts_q != '0 && pkt_inc == pkts_q)) begin
                                state_d = StIdle;
                                done_d  = 1'b1;
                                stop_d  = 1'b0;
                            end else if (gap_q != '0) begin
                                state_d   = StGap;
                                gap_cnt_d = gap_q;
                            end
                        end else begin
                            beat_d = beat_q + LEN_W'(1);
                        end
                    end
                end
                StGap: begin
                    if (stop_seen) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        stop_d  = 1'b0;
                    end else if (gap_cnt_q == GAP_W'(1)) begin
                        state_d = StSend;
                    end else begin
                        gap_cnt_d = gap_cnt_q - GAP_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= StIdle;
                len_q     <= '0;
                pkts_q    <= '0;
                gap_q     <= '0;
                beat_q    <= '0;
                pkt_cnt_q <= '0;
                gap_cnt_q <= '0;
                data_q    <= '0;
                stop_q    <= 1'b0;
                done_q    <= 1'b0;
`ifdef AXIS_PRODUCER_LFSR_EN
                mode_q    <= 1'b0;
`endif
            end else begin
                state_q   <= state_d;
                len_q     <= len_d;
                pkts_q    <= pkts_d;
                gap_q     <= gap_d;
                beat_q    <= beat_d;
                pkt_cnt_q <= pkt_cnt_d;
                gap_cnt_q <= gap_cnt_d;
                data_q    <= data_d;
                stop_q    <= stop_d;
                done_q    <= done_d;
`ifdef AXIS_PRODUCER_LFSR_EN
                mode_q    <= mode_d;
`endif
            end
        end

        assign tvalid[c]                     = state_q == StSend;
        assign tlast[c]                      = (state_q == StSend) && last_beat;
        assign busy[c]                       = is_busy;
        assign done[c]                       = done_q;
        assign tdata[c*DATA_W +: DATA_W]     = data_q;
    end

endmodule

// File: tb/tb_axis_multi_producer.sv
// tb_axis_multi_producer: randomized packet runs checked against a per-run beat-sequence model.
module tb_axis_multi_producer;
    localparam int NUM_CH = 2;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;
    localparam int CNT_W  = 16;
    localparam int GAP_W  = 4;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_CH-1:0]        start, stop, tvalid, tready, tlast, busy, done;
    logic [LEN_W-1:0]         cfg_len;
    logic [CNT_W-1:0]         cfg_pkts;
    logic [GAP_W-1:0]         cfg_gap;
    logic [DATA_W-1:0]        cfg_seed;
    logic                     cfg_mode;
    logic [NUM_CH*DATA_W-1:0] tdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axis_multi_producer #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W),
        .CNT_W  (CNT_W),
        .GAP_W  (GAP_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .cfg_len  (cfg_len),
        .cfg_pkts (cfg_pkts),
        .cfg_gap  (cfg_gap),
        .cfg_seed (cfg_seed),
        .cfg_mode (cfg_mode),
        .tvalid   (tvalid),
        .tready   (tready),
        .tlast    (tlast),
        .tdata    (tdata),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // One run on channel c. stop_pkt != 0 requests stop during that packet (beat 2, or the
    // first gap cycle after it when stop_in_gap). Expected beats are derived from the rules.
    task automatic run(input int c, input int len, input int pkts, input int gap,
                       input logic [31:0] seed, input int rdy, input int stop_pkt,
                       input bit stop_in_gap, input bit mode);
        int len_e, total, stop_idx, idx, obs_idx, cyc, last_hs, done_cyc, stop_cyc;
        bit stop_on, stop_sent;
        logic [31:0] exp_d;
        len_e    = (len == 0) ? 1 : len;
        stop_on  = (stop_pkt != 0) && (pkts == 0 || stop_pkt < pkts);
        total    = (stop_on ? stop_pkt : pkts) * len_e;
        stop_idx = (stop_pkt - 1) * len_e + ((len_e > 2) ? 2 : len_e - 1);
        exp_d    = (mode && seed == 32'h0) ? 32'hFFFF_FFFF : seed;

        @(negedge clk);
        cfg_len  = LEN_W'(len);
        cfg_pkts = CNT_W'(pkts);
        cfg_gap  = GAP_W'(gap);
        cfg_seed = seed;
        cfg_mode = mode;
        start[c] = 1'b1;
        @(negedge clk);
        start[c] = 1'b0;
        check("valid_after_start", tvalid[c], 1'b1);

        idx = 0; obs_idx = -1; cyc = 0; last_hs = -1; done_cyc = -1; stop_cyc = -1;
        stop_sent = 1'b0;
        while (cyc < 2000) begin
            if (done[c]) begin
                done_cyc = cyc;
                break;
            end
            if (!busy[c]) break;
            case (rdy)
                0:       tready[c] = 1'b1;
                1:       tready[c] = (cyc % 2 == 0);
                default: tready[c] = ($urandom_range(0, 1) == 1);
            endcase
            if (stop_on && !stop_sent &&
                (stop_in_gap ? (!tvalid[c] && idx == total) : (tvalid[c] && idx == stop_idx))) begin
                stop[c]   = 1'b1;
                stop_sent = 1'b1;
                stop_cyc  = cyc;
            end
            if (cyc == 2) begin
                // Restart attempt while busy must be ignored.
                start[c] = 1'b1;
                cfg_seed = ~seed;
                cfg_len  = LEN_W'(len + 1);
            end
            if (!tvalid[c] && (idx % len_e) != 0 && idx < total)
                check("no_bubble", tvalid[c], 1'b1);
            if (tvalid[c]) begin
                if (idx >= total) begin
                    check("extra_beat", tvalid[c], 1'b0);
                    break;
                end
                if (idx != obs_idx) begin
                    obs_idx = idx;
                    if (idx > 0 && (idx % len_e) == 0) check("gap_len", cyc - last_hs - 1, gap);
                end
                check("tdata", tdata[c*DATA_W +: DATA_W], exp_d);
                check("tlast", tlast[c], (idx % len_e) == len_e - 1);
                if (tready[c]) begin
                    idx++;
                    last_hs = cyc;
                    exp_d   = mode ? lfsr_next(exp_d) : exp_d + 32'd1;
                end
            end
            @(negedge clk);
            start[c] = 1'b0;
            stop[c]  = 1'b0;
            cyc++;
        end
        start[c]  = 1'b0;
        stop[c]   = 1'b0;
        tready[c] = 1'b0;
        check("beat_count", idx, total);
        check("done_cycle", done_cyc, (stop_on && stop_in_gap) ? stop_cyc + 1 : last_hs + 1);
        check("busy_at_done", busy[c], 1'b0);
        check("valid_at_done", tvalid[c], 1'b0);
        @(negedge clk);
        check("done_width", done[c], 1'b0);
        check("other_idle", busy[1-c], 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = '0;
        stop     = '0;
        tready   = '0;
        cfg_len  = '0;
        cfg_pkts = '0;
        cfg_gap  = '0;
        cfg_seed = '0;
        cfg_mode = 1'b0;
        #12;
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tdata", tdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run(0, 4, 2, 0, 32'h10, 0, 0, 1'b0, 1'b0);
        run(1, 3, 2, 2, 32'h100, 1, 0, 1'b0, 1'b0);
        run(0, 5, 0, 0, 32'h2000, 0, 3, 1'b0, 1'b0);
        run(1, 3, 1, 0, 32'hFFFF_FFFE, 0, 0, 1'b0, 1'b0);
        run(1, 2, 0, 3, 32'h77, 2, 2, 1'b1, 1'b0);
        run(0, 0, 2, 1, 32'h40, 2, 0, 1'b0, 1'b0);

        // Async reset while a last beat is presented.
        @(negedge clk);
        cfg_len  = 8'd1;
        cfg_pkts = 16'd1;
        cfg_gap  = 4'd0;
        cfg_seed = 32'hA5;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        check("pre_rst_last", tlast[0], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", tvalid[0], 1'b0);
        check("async_rst_last", tlast[0], 1'b0);
        check("async_rst_busy", busy[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run(0, 3, 1, 0, 32'h55, 0, 0, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            run(int'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), $urandom, 2, 0,
                1'b0, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            run(int'($urandom_range(0, 1)), int'($urandom_range(1, 5)), 0,
                int'($urandom_range(0, 2)), $urandom, 2, int'($urandom_range(1, 3)),
                1'b0, 1'b0);
        end

`ifdef AXIS_PRODUCER_LFSR_EN
        run(0, 4, 2, 1, 32'h0, 2, 0, 1'b0, 1'b1);
        run(1, 3, 2, 0, 32'h1234_5678, 0, 0, 1'b0, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axis_multi_producer.md
Name: axis_multi_producer

Overview:
- Parametrised AXI4-Stream traffic producer: NUM_CH independent stream generators, each emitting packets of programmable length and count with a programmable inter-packet gap.
- Successor to the fixed-channel producer: generalises data width, channel count and packet shaping, and adds real generator behaviour.
- Sits in the axiDemo testbench/system top and drives consumer-side axi4_stream_if sinks.

Parameters:
NUM_CH, 2, number of independent stream channels (1..8)
DATA_W, 32, tdata width per channel in bits (8..128, multiple of 8)
LEN_W, 8, width of packet-length field; maximum packet length is 2^LEN_W-1 beats
CNT_W, 16, width of packet-count field
GAP_W, 4, width of inter-packet-gap field

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  NUM_CH  per-channel single-cycle start pulse; latches shared cfg_* into that channel
stop  input  NUM_CH  per-channel stop request; current packet completes, then IDLE
cfg_len  input  LEN_W  beats per packet; 0 is treated as 1
cfg_pkts  input  CNT_W  packets to send; 0 means continuous until stop
cfg_gap  input  GAP_W  idle cycles inserted after each packet's last beat
cfg_seed  input  DATA_W  first data word of the run
cfg_mode  input  1  pattern select, 0 = incrementing, 1 = LFSR (only with the optional feature)
tvalid  output  NUM_CH  per-channel AXI-S valid
tready  input  NUM_CH  per-channel AXI-S ready
tlast  output  NUM_CH  per-channel end of packet
tdata  output  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
busy  output  NUM_CH  channel not in IDLE
done  output  NUM_CH  single-cycle pulse when a channel returns to IDLE

Behaviour:
- Reset (async assert, sync deassert inside the block) forces every output to 0, all channels to IDLE, and all counters and latched cfg to 0. Reset mid-packet drops the packet with no tlast.
- Per-channel FSM: IDLE -> SEND -> (GAP) -> SEND ... -> IDLE. Channels are fully independent.
- IDLE: when start[c]=1, latch cfg_*, load data register with cfg_seed, clear beat and packet counters, go to SEND next cycle; tvalid rises 1 cycle after start. start while busy is ignored.
- SEND: tvalid=1. tdata and tlast hold stable until tvalid&tready; tvalid never drops without a handshake. On each handshake: beat counter +1, data advances (incrementing: +1 modulo 2^DATA_W, wraps silently).
- tlast=1 when beat counter == len-1. On the handshake of the last beat, packet counter +1 and beat counter clears. Next state:
  - IDLE if stop was seen, or if pkts!=0 and packet count == pkts;
  - otherwise GAP if gap!=0;
  - otherwise SEND (back-to-back packets, no bubble).
- GAP: tvalid=0 for exactly gap cycles, then SEND.
- stop[c] is sticky per run: it is captured at any time while busy and cleared on entry to IDLE. It never truncates a packet. stop while in GAP -> IDLE on the next cycle.
- stop and the last-beat handshake in the same cycle -> IDLE. start and stop together in IDLE -> start wins, stop is ignored.
- done[c] pulses for 1 cycle on the cycle the FSM enters IDLE from SEND/GAP. busy falls that same cycle.
- Data continues across packets; it does not restart at the seed per packet.
- Packet-count overflow in continuous mode wraps silently.

Optional Feature:
AXIS_PRODUCER_LFSR_EN
- Defined: cfg_mode=1 selects a DATA_W-bit Galois LFSR per channel, advanced one step per handshake. A seed of 0 is replaced by all-ones to avoid lockup. cfg_mode=0 keeps incrementing data.
- Not defined: the LFSR logic is absent, cfg_mode is ignored, and data is always incrementing.

Test Plan:
- NUM_CH=2, ch0 start, len=4, pkts=2, gap=0, seed=0x10, tready=1 -> 8 consecutive beats 0x10..0x17, tlast on 0x13 and 0x17, done pulse one cycle after the 0x17 handshake.
- ch1 len=3, gap=2, pkts=2, tready toggling 1010... -> tvalid/tdata/tlast stable while tready=0, exactly 2 idle cycles between packets.
- ch0 pkts=0 (continuous), len=5, stop asserted on beat 2 of packet 3 -> packet 3 completes through tlast, then IDLE and done.
- seed=0xFFFFFFFE, len=3 -> data 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 (wrap).
- rst_n asserted mid-packet with tvalid=1 -> tvalid/tlast/busy=0 immediately (async), and a new start afterwards begins again from the seed.
- With AXIS_PRODUCER_LFSR_EN, cfg_mode=1, seed=0 -> first word all-ones, subsequent words match the reference LFSR model; start on ch0 while ch0 is busy is ignored.
